// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_responder
// Description : SPI mode-0 responder. The sclk, cs_n and mosi pins are
//               oversampled and synchronised into clk; nothing runs on sclk.
//               Received words appear on rx_data with a one-cycle rx_valid
//               pulse. Reply words are offered through a one-word holding
//               buffer (tx_valid/tx_ready).
//               Optional macro SPI_RESPONDER_ECHO_EN: when the holding buffer
//               is empty at a word start, the previous received word of the
//               current CS frame is echoed instead of TX_IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_responder #(
   parameter int              WIDTH       = 8,
   parameter int              SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] TX_IDLE    = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             spi_sclk,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_underrun,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                 sclk_dly_q, cs_dly_q;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]     shift_rx_q, shift_rx_d;
   logic [WIDTH-1:0]     shift_tx_q, shift_tx_d;
   logic                 word_end_q, word_end_d;   // WIDTH-th rise seen, next fall starts a word
   logic                 done_q, done_d;           // shift_rx holds a complete word
   logic [WIDTH-1:0]     rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0]     buf_q, buf_d;
   logic                 buf_full_q, buf_full_d;
   logic                 underrun_q, underrun_d;
   logic                 miso_q, miso_d;

   logic                 w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_mosi;
   logic                 w_start;
   logic [WIDTH-1:0]     w_fill, w_load_word;

`ifdef SPI_RESPONDER_ECHO_EN
   logic                 echo_vld_q, echo_vld_d;
`endif

   // Edge detection on the last synchroniser stage versus one extra delay flop
   assign w_sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
   assign w_sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_dly_q;
   assign w_cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_dly_q;
   assign w_cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_dly_q;
   assign w_mosi      = mosi_sync_q[SYNC_STAGES-1];

   // Pin synchronisers and edge-detect delay flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_dly_q  <= 1'b0;
         cs_dly_q    <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
         cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   // Next state: SHIFT for the whole time chip select is asserted
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (w_cs_fall) state_d = SHIFT;
         SHIFT:   if (w_cs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Word sent when the holding buffer is empty
`ifdef SPI_RESPONDER_ECHO_EN
   assign w_fill = (w_cs_fall || !echo_vld_q) ? TX_IDLE : rx_data_q;
`else
   assign w_fill = TX_IDLE;
`endif

   assign w_load_word = buf_full_q ? buf_q : w_fill;
   // A word starts at chip-select fall, or at the sclk fall closing the previous word
   assign w_start = ((state_q == IDLE) && w_cs_fall) ||
                    ((state_q == SHIFT) && !w_cs_rise && w_sclk_fall && word_end_q);

   // Datapath next-state: shifters, bit counter, rx word, tx holding buffer
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_rx_d = shift_rx_q;
      shift_tx_d = shift_tx_q;
      word_end_d = word_end_q;
      done_d     = 1'b0;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      underrun_d = 1'b0;
      miso_d     = miso_q;
`ifdef SPI_RESPONDER_ECHO_EN
      echo_vld_d = echo_vld_q;
`endif

      if ((state_q == SHIFT) && w_sclk_rise) begin
         shift_rx_d = {shift_rx_q[WIDTH-2:0], w_mosi};
         if (bit_cnt_q == CNT_W'(WIDTH-1)) begin
            bit_cnt_d  = '0;
            done_d     = 1'b1;
            word_end_d = 1'b1;
         end else begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
         end
      end

      if ((state_q == SHIFT) && w_sclk_fall && !w_cs_rise && !word_end_q) begin
         shift_tx_d = shift_tx_q << 1;
         miso_d     = shift_tx_q[WIDTH-2];
      end

      // Consuming the buffer happens before a new offer can be accepted
      if (w_start) begin
         shift_tx_d = w_load_word;
         miso_d     = w_load_word[WIDTH-1];
         word_end_d = 1'b0;
         if (buf_full_q) buf_full_d = 1'b0;
         else            underrun_d = 1'b1;
      end

      if (tx_valid && !buf_full_q) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end

      // Chip-select release discards any partial word but keeps the buffer
      if ((state_q == SHIFT) && w_cs_rise) begin
         bit_cnt_d  = '0;
         word_end_d = 1'b0;
         miso_d     = 1'b0;
      end

      if (done_q) begin
         rx_data_d  = shift_rx_q;
         rx_valid_d = 1'b1;
`ifdef SPI_RESPONDER_ECHO_EN
         echo_vld_d = 1'b1;
`endif
      end

`ifdef SPI_RESPONDER_ECHO_EN
      if (w_cs_fall) echo_vld_d = 1'b0;
`endif
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_rx_q <= '0;
         shift_tx_q <= '0;
         word_end_q <= 1'b0;
         done_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         underrun_q <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_rx_q <= shift_rx_d;
         shift_tx_q <= shift_tx_d;
         word_end_q <= word_end_d;
         done_q     <= done_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         underrun_q <= underrun_d;
         miso_q     <= miso_d;
      end
   end

`ifdef SPI_RESPONDER_ECHO_EN
   // Echo source is valid only once a word has been received in this frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) echo_vld_q <= 1'b0;
      else        echo_vld_q <= echo_vld_d;
   end
`endif

   assign spi_miso    = miso_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ready    = ~buf_full_q;
   assign tx_underrun = underrun_q;
   assign busy        = (state_q == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_responder
// Description : Directed self-checking bench for spi_responder (WIDTH=8,
//               SYNC_STAGES=2, sclk = clk/8). Honours SPI_RESPONDER_ECHO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_sclk, spi_cs_n, spi_mosi;
   logic       spi_miso;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_underrun, busy;

   int n_chk = 0;
   int n_err = 0;
   int rxv_cnt = 0;
   int und_cnt = 0;

   spi_responder #(.WIDTH(8), .SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (rx_valid === 1'b1)    rxv_cnt++;
      if (tx_underrun === 1'b1) und_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One host bit: mosi set while sclk low, miso sampled just before the rise
   task automatic host_bit(input logic b, output logic m);
      spi_mosi = b;
      repeat (4) @(negedge clk);
      m = spi_miso;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
   endtask

   // One full word; checks rx_valid latency (SYNC_STAGES+2 edges) on the last rise
   task automatic xfer(input logic [7:0] mo, input bit last, output logic [7:0] mi);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = mo[i];
         repeat (4) @(negedge clk);
         mi[i] = spi_miso;
         spi_sclk = 1'b1;
         if (i == 0) begin
            repeat (3) @(negedge clk);
            chk("rx_valid_early", rx_valid, 1'b0);
            @(negedge clk);
            chk("rx_valid_latency", rx_valid, 1'b1);
            chk("rx_data", rx_data, mo);
         end else begin
            repeat (4) @(negedge clk);
         end
         if (!(i == 0 && last)) spi_sclk = 1'b0;
      end
   endtask

   // Close a frame whose last word left sclk high: CS released before sclk drops
   task automatic end_frame();
      repeat (2) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic load_tx(input logic [7:0] d);
      int n = 0;
      tx_data = d;
      while (tx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("tx_ready_wait", tx_ready, 1'b1);
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("tx_ready_drop", tx_ready, 1'b0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_miso"},     spi_miso,    1'b0);
      chk({tag, "_rx_data"},  rx_data,     8'h00);
      chk({tag, "_rx_valid"}, rx_valid,    1'b0);
      chk({tag, "_tx_ready"}, tx_ready,    1'b1);
      chk({tag, "_underrun"}, tx_underrun, 1'b0);
      chk({tag, "_busy"},     busy,        1'b0);
   endtask

   initial begin
      logic [7:0] mi, m1, m2, m3;
      logic       mb;
      logic [7:0] exp3;
      int r0, u0;

`ifdef SPI_RESPONDER_ECHO_EN
      exp3 = 8'h34;
`else
      exp3 = 8'hFF;
`endif
      rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: A5 with empty buffer -> idle word on MISO, one underrun
      r0 = rxv_cnt; u0 = und_cnt;
      spi_cs_n = 1'b0;
      xfer(8'hA5, 1'b1, mi);
      chk("t1_busy", busy, 1'b1);
      end_frame();
      chk("t1_miso", mi, 8'hFF);
      chk("t1_rxv_count", rxv_cnt - r0, 1);
      chk("t1_underrun_count", und_cnt - u0, 1);
      chk("t1_busy_after", busy, 1'b0);

      // 2: preloaded 3C is consumed at CS fall
      load_tx(8'h3C);
      u0 = und_cnt;
      spi_cs_n = 1'b0;
      @(negedge clk);
      chk("t2_ready_before", tx_ready, 1'b0);
      repeat (2) @(negedge clk);
      chk("t2_ready_after", tx_ready, 1'b1);
      xfer(8'h00, 1'b1, mi);
      end_frame();
      chk("t2_miso", mi, 8'h3C);
      chk("t2_underrun_count", und_cnt - u0, 0);

      // 3: three back-to-back words in one frame
      r0 = rxv_cnt; u0 = und_cnt;
      load_tx(8'hC1);
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
      load_tx(8'hC2);
      xfer(8'h12, 1'b0, m1);
      xfer(8'h34, 1'b0, m2);
      xfer(8'h56, 1'b1, m3);
      end_frame();
      chk("t3_miso0", m1, 8'hC1);
      chk("t3_miso1", m2, 8'hC2);
      chk("t3_miso2", m3, exp3);
      chk("t3_rxv_count", rxv_cnt - r0, 3);
      chk("t3_underrun_count", und_cnt - u0, 1);

      // 4: CS released after 5 bits of F0, then a full 81
      r0 = rxv_cnt;
      spi_cs_n = 1'b0;
      for (int i = 7; i >= 3; i--) begin
         logic [7:0] pat;
         pat = 8'hF0;
         host_bit(pat[i], mb);
      end
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("t4_no_rxv", rxv_cnt - r0, 0);
      chk("t4_busy", busy, 1'b0);
      chk("t4_rx_hold", rx_data, 8'h56);
      chk("t4_miso_low", spi_miso, 1'b0);
      spi_cs_n = 1'b0;
      xfer(8'h81, 1'b1, mi);
      end_frame();
      chk("t4_miso", mi, 8'hFF);
      chk("t4_rxv_count", rxv_cnt - r0, 1);

      // 5: reset mid-transfer with 77 buffered
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
      load_tx(8'h77);
      for (int i = 0; i < 3; i++) host_bit(1'b1, mb);
      rst_n = 1'b0;
      spi_cs_n = 1'b1;
      spi_sclk = 1'b0;
      #1;
      chk_reset_vals("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b0;
      xfer(8'h5A, 1'b1, mi);
      end_frame();
      chk("t5_miso_idle", mi, 8'hFF);

      // 6: sclk activity with CS high is ignored
      r0 = rxv_cnt;
      for (int i = 0; i < 20; i++) begin
         spi_mosi = 1'($urandom_range(0, 1));
         repeat (2) @(negedge clk);
         spi_sclk = ~spi_sclk;
         if (spi_miso !== 1'b0) chk("t6_miso_during", spi_miso, 1'b0);
      end
      spi_sclk = 1'b0;
      repeat (8) @(negedge clk);
      chk("t6_no_rxv", rxv_cnt - r0, 0);
      chk("t6_miso", spi_miso, 1'b0);
      chk("t6_busy", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
